// File: rtl/fft_report_pkg.sv
// Shared definitions for the FFT report scheduler: snapshot geometry, frame
// sizing, FSM state encoding and the payload byte selector.
package fft_report_pkg;

  localparam int unsigned NUM_BINS      = 8;
  localparam int unsigned BIN_W         = 32;
  localparam int unsigned SNAP_W        = NUM_BINS * BIN_W;
  localparam int unsigned BYTES_PER_BIN = BIN_W / 8;
  localparam int unsigned PAY_BYTES     = NUM_BINS * BIN_W / 8;
  localparam int unsigned FRAME_BYTES   = PAY_BYTES + 3;
  localparam int unsigned IDX_W         = (PAY_BYTES > 1) ? $clog2(PAY_BYTES) : 1;

  localparam logic [7:0] SYNC_BYTE_DEF  = 8'hA5;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    SEND_SYNC = 3'd1,
    SEND_SEQ  = 3'd2,
    SEND_PAY  = 3'd3,
    SEND_CSUM = 3'd4
  } state_e;

  // Payload byte idx: bin 0 first, most significant byte of each bin first.
  function automatic logic [7:0] pay_byte(input logic [SNAP_W-1:0] snap,
                                          input logic [IDX_W-1:0]  idx);
    int unsigned        bin_i;
    int unsigned        sub_i;
    int unsigned        lsb;
    logic [SNAP_W-1:0]  sh;
    bin_i = 32'(idx) / BYTES_PER_BIN;
    sub_i = 32'(idx) % BYTES_PER_BIN;
    lsb   = bin_i * BIN_W + (BYTES_PER_BIN - 1 - sub_i) * 8;
    sh    = snap >> lsb;
    return sh[7:0];
  endfunction

endpackage

// File: rtl/fft_report_scheduler.sv
// Captures an FFT magnitude snapshot on fft_done and streams it to the host
// link as a framed byte sequence: SYNC, SEQ, payload (bin 0 first, MSB byte
// first), CSUM (XOR of SEQ and payload). A holdoff counter rate-limits frames
// and rejected snapshot requests are counted so the audio side never stalls.
// Bin geometry (NUM_BINS, BIN_W) comes from fft_report_pkg.
//
// Ports:
//   i_clk, i_rst_n          clock, asynchronous active-low reset
//   i_fft_done, i_freqs     snapshot strobe and bin bus (bin k at [k*BIN_W +: BIN_W])
//   i_enable                permits new captures
//   o_tx_data, o_tx_valid,
//   i_tx_ready              valid/ready byte stream toward UART TX
//   o_busy                  frame in progress
//   o_frame_cnt             completed frames (wrapping)
//   o_drop_cnt              rejected enabled strobes (saturating)
module fft_report_scheduler
  import fft_report_pkg::*;
#(
  parameter logic [7:0]  SYNC_BYTE      = SYNC_BYTE_DEF,
  parameter int unsigned HOLDOFF_CYCLES = 120000
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_fft_done,
  input  logic [SNAP_W-1:0] i_freqs,
  input  logic              i_enable,
  output logic [7:0]        o_tx_data,
  output logic              o_tx_valid,
  input  logic              i_tx_ready,
  output logic              o_busy,
  output logic [7:0]        o_frame_cnt,
  output logic [7:0]        o_drop_cnt
);

  localparam int unsigned    HO_W     = (HOLDOFF_CYCLES > 0) ? $clog2(HOLDOFF_CYCLES + 1) : 1;
  localparam logic [HO_W-1:0]  HO_LOAD  = HO_W'(HOLDOFF_CYCLES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PAY_BYTES - 1);

  state_e             state_q, state_d;
  logic [SNAP_W-1:0]  snap_q, snap_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [7:0]         csum_q, csum_d;
  logic [7:0]         frame_q, frame_d;
  logic [7:0]         drop_q, drop_d;
  logic [HO_W-1:0]    holdoff_q, holdoff_d;
  logic [7:0]         tx_data_q, tx_data_d;
  logic               tx_valid_q, tx_valid_d;
  logic               busy_q, busy_d;

  logic xfer;
  logic req;
  logic capture;

  assign xfer    = tx_valid_q & i_tx_ready;
  assign req     = i_fft_done & i_enable;
  assign capture = (state_q == IDLE) & req & (holdoff_q == '0);

  // State register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic: every non-idle state advances only on a byte transfer.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (capture) state_d = SEND_SYNC;
      SEND_SYNC: if (xfer) state_d = SEND_SEQ;
      SEND_SEQ:  if (xfer) state_d = SEND_PAY;
      SEND_PAY:  if (xfer && (idx_q == LAST_IDX)) state_d = SEND_CSUM;
      SEND_CSUM: if (xfer) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  // Datapath and output next values.
  always_comb begin
    snap_d    = snap_q;
    idx_d     = idx_q;
    csum_d    = csum_q;
    frame_d   = frame_q;
    drop_d    = drop_q;
    holdoff_d = holdoff_q;

    if (capture) snap_d = i_freqs;
    if (req && !capture && (drop_q != 8'hFF)) drop_d = drop_q + 8'd1;
    if ((state_q == IDLE) && (holdoff_q != '0)) holdoff_d = holdoff_q - HO_W'(1);

    // Checksum accumulates the byte leaving the link, so it covers SEQ and payload only.
    if (xfer) begin
      case (state_q)
        SEND_SEQ: csum_d = csum_q ^ tx_data_q;
        SEND_PAY: begin
          csum_d = csum_q ^ tx_data_q;
          idx_d  = (idx_q == LAST_IDX) ? '0 : idx_q + IDX_W'(1);
        end
        SEND_CSUM: begin
          csum_d    = 8'h00;
          idx_d     = '0;
          frame_d   = frame_q + 8'd1;
          holdoff_d = HO_LOAD;
        end
        default: ;
      endcase
    end

    tx_valid_d = (state_d != IDLE);
    busy_d     = (state_d != IDLE);

    // Recomputed every cycle; inputs to each case are frozen while stalled.
    case (state_d)
      SEND_SYNC: tx_data_d = SYNC_BYTE;
      SEND_SEQ:  tx_data_d = frame_q;
      SEND_PAY:  tx_data_d = pay_byte(snap_q, idx_d);
      SEND_CSUM: tx_data_d = csum_d;
      default:   tx_data_d = 8'h00;
    endcase
  end

  // Datapath registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      snap_q     <= '0;
      idx_q      <= '0;
      csum_q     <= 8'h00;
      frame_q    <= 8'h00;
      drop_q     <= 8'h00;
      holdoff_q  <= '0;
      tx_data_q  <= 8'h00;
      tx_valid_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      snap_q     <= snap_d;
      idx_q      <= idx_d;
      csum_q     <= csum_d;
      frame_q    <= frame_d;
      drop_q     <= drop_d;
      holdoff_q  <= holdoff_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
      busy_q     <= busy_d;
    end
  end

  assign o_tx_data   = tx_data_q;
  assign o_tx_valid  = tx_valid_q;
  assign o_busy      = busy_q;
  assign o_frame_cnt = frame_q;
  assign o_drop_cnt  = drop_q;

endmodule

// File: tb/tb_fft_report_scheduler.sv
// Bench for fft_report_scheduler: directed sequence with randomized bins and
// ready patterns, checked against a frame model built from the bin values.
module tb_fft_report_scheduler;

  logic         clk;
  logic         rst_n;
  logic         fft_done;
  logic [255:0] freqs;
  logic         enable;
  logic [7:0]   tx_data;
  logic         tx_valid;
  logic         tx_ready;
  logic         busy;
  logic [7:0]   frame_cnt;
  logic [7:0]   drop_cnt;

  int checks = 0;
  int errors = 0;

  logic [31:0] ref_bins [8];
  logic [7:0]  got [$];
  logic [7:0]  expq [$];
  int          exp_frames = 0;
  int          last_cyc;

  fft_report_scheduler #(
    .SYNC_BYTE      (8'hA5),
    .HOLDOFF_CYCLES (4)
  ) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_fft_done  (fft_done),
    .i_freqs     (freqs),
    .i_enable    (enable),
    .o_tx_data   (tx_data),
    .o_tx_valid  (tx_valid),
    .i_tx_ready  (tx_ready),
    .o_busy      (busy),
    .o_frame_cnt (frame_cnt),
    .o_drop_cnt  (drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic rand_bins();
    for (int k = 0; k < 8; k++) ref_bins[k] = $urandom;
  endtask

  // Expected frame straight from the framing rules.
  task automatic build_exp(input logic [7:0] seq);
    logic [7:0] b;
    logic [7:0] cs;
    expq.delete();
    expq.push_back(8'hA5);
    expq.push_back(seq);
    cs = seq;
    for (int k = 0; k < 32; k++) begin
      b = 8'(ref_bins[k / 4] >> (8 * (3 - (k % 4))));
      expq.push_back(b);
      cs = cs ^ b;
    end
    expq.push_back(cs);
  endtask

  // Strobe fft_done with ref_bins; afterwards SYNC must be presented.
  task automatic capture();
    for (int k = 0; k < 8; k++) freqs[k*32 +: 32] = ref_bins[k];
    fft_done = 1'b1;
    @(negedge clk);
    fft_done = 1'b0;
    chk("lat_valid", 32'(tx_valid), 32'd1);
    chk("lat_sync", 32'(tx_data), 32'hA5);
  endtask

  // Drain one frame. p1/p2: byte index at whose transfer an enabled strobe is
  // raised. chg: byte index from which enable drops, bins change and fft_done
  // is held high.
  task automatic run_frame(input bit rnd, input int p1, input int p2, input int chg);
    int         n;
    int         cyc;
    bit         hold;
    logic [7:0] prev;
    got.delete();
    hold = 1'b0;
    prev = 8'h00;
    cyc  = 0;
    while (tx_valid && cyc < 2000) begin
      if (hold) chk("stable", 32'(tx_data), 32'(prev));
      n = got.size();
      tx_ready = rnd ? 1'($urandom_range(1, 0)) : 1'b1;
      fft_done = ((n == p1) || (n == p2)) && tx_ready;
      if (chg >= 0 && n >= chg) begin
        enable   = 1'b0;
        fft_done = 1'b1;
        if (n == chg) for (int k = 0; k < 8; k++) freqs[k*32 +: 32] = $urandom;
      end
      if (tx_ready) got.push_back(tx_data);
      hold = !tx_ready;
      prev = tx_data;
      @(negedge clk);
      fft_done = 1'b0;
      cyc++;
    end
    tx_ready = 1'b1;
    last_cyc = cyc;
    chk("frame_end", 32'(tx_valid), 32'd0);
  endtask

  task automatic check_frame();
    build_exp(8'(exp_frames));
    chk("frame_len", 32'(got.size()), 32'(expq.size()));
    for (int i = 0; i < expq.size() && i < got.size(); i++)
      chk($sformatf("byte%0d", i), 32'(got[i]), 32'(expq[i]));
    exp_frames++;
    chk("frame_cnt", 32'(frame_cnt), 32'(exp_frames % 256));
    chk("busy_after", 32'(busy), 32'd0);
  endtask

  task automatic wait_holdoff();
    repeat (6) @(negedge clk);
  endtask

  initial begin
    rst_n    = 1'b0;
    fft_done = 1'b0;
    freqs    = '0;
    enable   = 1'b1;
    tx_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_valid", 32'(tx_valid), 32'd0);
    chk("rst_data", 32'(tx_data), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_frame", 32'(frame_cnt), 32'd0);
    chk("rst_drop", 32'(drop_cnt), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Ready held high: known pattern, 35 back-to-back bytes.
    for (int k = 0; k < 8; k++) ref_bins[k] = 32'h0102_0300 + 32'(k);
    capture();
    run_frame(1'b0, -1, -1, -1);
    chk("frame_cycles", 32'(last_cyc), 32'd35);
    check_frame();

    // Same pattern under random backpressure.
    wait_holdoff();
    capture();
    run_frame(1'b1, -1, -1, -1);
    check_frame();

    // Drops: mid-frame, on CSUM transfer, two cycles into holdoff.
    wait_holdoff();
    rand_bins();
    capture();
    run_frame(1'b1, 10, 34, -1);
    check_frame();
    @(negedge clk);
    fft_done = 1'b1;
    @(negedge clk);
    fft_done = 1'b0;
    chk("drop3", 32'(drop_cnt), 32'd3);
    chk("drop3_idle", 32'(busy), 32'd0);
    chk("drop3_frames", 32'(frame_cnt), 32'(exp_frames));
    // Last holdoff cycle still rejects; the next one captures.
    repeat (1) @(negedge clk);
    fft_done = 1'b1;
    @(negedge clk);
    fft_done = 1'b0;
    chk("ho_edge_drop", 32'(drop_cnt), 32'd4);
    chk("ho_edge_idle", 32'(busy), 32'd0);
    rand_bins();
    capture();
    run_frame(1'b0, -1, -1, -1);
    check_frame();

    // Drop saturation while stalled.
    wait_holdoff();
    rand_bins();
    capture();
    tx_ready = 1'b0;
    repeat (300) begin
      fft_done = 1'b1;
      @(negedge clk);
    end
    fft_done = 1'b0;
    chk("drop_sat", 32'(drop_cnt), 32'd255);
    chk("stall_valid", 32'(tx_valid), 32'd1);
    chk("stall_data", 32'(tx_data), 32'hA5);
    run_frame(1'b1, -1, -1, -1);
    check_frame();

    // Sequence wrap over 257 frames.
    while (exp_frames < 257) begin
      wait_holdoff();
      rand_bins();
      capture();
      run_frame(1'b0, -1, -1, -1);
      check_frame();
    end
    chk("wrap_frame", 32'(frame_cnt), 32'd1);
    chk("wrap_drop", 32'(drop_cnt), 32'd255);

    // Reset mid-frame at payload byte 5.
    wait_holdoff();
    rand_bins();
    capture();
    repeat (7) @(negedge clk);
    build_exp(8'(exp_frames));
    chk("pre_rst_byte", 32'(tx_data), 32'(expq[7]));
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", 32'(tx_valid), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_frame", 32'(frame_cnt), 32'd0);
    chk("arst_drop", 32'(drop_cnt), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    exp_frames = 0;
    rand_bins();
    capture();
    run_frame(1'b1, -1, -1, -1);
    check_frame();

    // Enable drop and bin change mid-frame: original snapshot goes out.
    wait_holdoff();
    rand_bins();
    capture();
    run_frame(1'b1, -1, -1, 8);
    check_frame();
    wait_holdoff();
    repeat (3) begin
      fft_done = 1'b1;
      @(negedge clk);
      fft_done = 1'b0;
      @(negedge clk);
    end
    chk("en_off_busy", 32'(busy), 32'd0);
    chk("en_off_valid", 32'(tx_valid), 32'd0);
    chk("en_off_drop", 32'(drop_cnt), 32'd0);
    chk("en_off_frame", 32'(frame_cnt), 32'(exp_frames));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
